// File: rtl/tri_raster_gen_if.sv
// Vertex-load and pixel-stream signals for tri_raster_gen.
// The master drives vertices; the slave (rasteriser) returns pixels.
interface tri_raster_gen_if #(parameter int CW = 3);
  logic          nt;
  logic [CW-1:0] xi;
  logic [CW-1:0] yi;
  logic          busy;
  logic          po;
  logic [CW-1:0] xo;
  logic [CW-1:0] yo;
  logic          done;

  modport master (output nt, xi, yi, input busy, po, xo, yo, done);
  modport slave  (input nt, xi, yi, output busy, po, xo, yo, done);
endinterface

// File: rtl/tri_raster_gen.sv
// Bounding-box triangle rasteriser: loads three vertices and streams covered pixels in raster order.
// Optional pixel counter output pix_cnt when TRI_RASTER_COUNT_EN is defined.
//   state | meaning
//   IDLE  | waiting for nt, V0 captured on nt
//   LOAD2 | capture V1
//   LOAD3 | capture V2
//   SETUP | bounding box, doubled area, degenerate check
//   SCAN  | one candidate per cycle, xmin..xmax within ymin..ymax
//   FIN   | done pulse, last pixel may coincide
module tri_raster_gen #(
  parameter int CW = 3
) (
  input  logic             clk,
  input  logic             reset,
  tri_raster_gen_if.slave  bus
`ifdef TRI_RASTER_COUNT_EN
  ,
  output logic [2*CW:0]    pix_cnt
`endif
);
  localparam int AW = 2*CW+3;

  typedef enum logic [2:0] {IDLE, LOAD2, LOAD3, SETUP, SCAN, FIN} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
  logic [CW-1:0]        x0_d, y0_d, x1_d, y1_d, x2_d, y2_d;
  logic [CW:0]          cx_q, cx_d, cy_q, cy_d;
  logic signed [AW-1:0] a2_q, a2_d;
  logic                 po_q, po_d;
  logic [CW-1:0]        xo_q, xo_d, yo_q, yo_d;

  logic [CW-1:0]        xmin, xmax, ymin, ymax;
  logic signed [AW-1:0] a2_c, e01, e12, e20;
  logic                 covered;

  function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, b, c);
    logic [CW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, b, c);
    logic [CW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic signed [AW-1:0] sx(input logic [CW:0] v);
    return $signed({{(AW-CW-1){1'b0}}, v});
  endfunction

  // Edge function of directed edge a->b at point p; the doubled area is edge(V0,V1) at V2.
  function automatic logic signed [AW-1:0] edge_fn(
    input logic signed [AW-1:0] ax, ay, bx, by, px, py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  always_comb begin
    xmin = min3(x0_q, x1_q, x2_q);
    xmax = max3(x0_q, x1_q, x2_q);
    ymin = min3(y0_q, y1_q, y2_q);
    ymax = max3(y0_q, y1_q, y2_q);
    a2_c = edge_fn(sx({1'b0, x0_q}), sx({1'b0, y0_q}), sx({1'b0, x1_q}), sx({1'b0, y1_q}),
                   sx({1'b0, x2_q}), sx({1'b0, y2_q}));
    e01  = edge_fn(sx({1'b0, x0_q}), sx({1'b0, y0_q}), sx({1'b0, x1_q}), sx({1'b0, y1_q}),
                   sx(cx_q), sx(cy_q));
    e12  = edge_fn(sx({1'b0, x1_q}), sx({1'b0, y1_q}), sx({1'b0, x2_q}), sx({1'b0, y2_q}),
                   sx(cx_q), sx(cy_q));
    e20  = edge_fn(sx({1'b0, x2_q}), sx({1'b0, y2_q}), sx({1'b0, x0_q}), sx({1'b0, y0_q}),
                   sx(cx_q), sx(cy_q));
    // Sign test against the area makes both windings cover the same inclusive pixel set.
    covered = ((a2_q > 0) && (e01 >= 0) && (e12 >= 0) && (e20 >= 0)) ||
              ((a2_q < 0) && (e01 <= 0) && (e12 <= 0) && (e20 <= 0));
  end

  always_comb begin
    state_d = state_q;
    x0_d = x0_q; y0_d = y0_q;
    x1_d = x1_q; y1_d = y1_q;
    x2_d = x2_q; y2_d = y2_q;
    cx_d = cx_q; cy_d = cy_q;
    a2_d = a2_q;
    po_d = 1'b0;
    xo_d = '0;
    yo_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.nt) begin
          x0_d = bus.xi;
          y0_d = bus.yi;
          state_d = LOAD2;
        end
      end
      LOAD2: begin
        x1_d = bus.xi;
        y1_d = bus.yi;
        state_d = LOAD3;
      end
      LOAD3: begin
        x2_d = bus.xi;
        y2_d = bus.yi;
        state_d = SETUP;
      end
      SETUP: begin
        a2_d = a2_c;
        cx_d = {1'b0, xmin};
        cy_d = {1'b0, ymin};
        state_d = (a2_c == '0) ? FIN : SCAN;
      end
      SCAN: begin
        if (covered) begin
          po_d = 1'b1;
          xo_d = cx_q[CW-1:0];
          yo_d = cy_q[CW-1:0];
        end
        if (cx_q == {1'b0, xmax}) begin
          if (cy_q == {1'b0, ymax}) begin
            state_d = FIN;
          end else begin
            cx_d = {1'b0, xmin};
            cy_d = cy_q + (CW+1)'(1);
          end
        end else begin
          cx_d = cx_q + (CW+1)'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x0_q <= '0; y0_q <= '0;
      x1_q <= '0; y1_q <= '0;
      x2_q <= '0; y2_q <= '0;
      cx_q <= '0; cy_q <= '0;
      a2_q <= '0;
      po_q <= 1'b0;
      xo_q <= '0;
      yo_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q <= x0_d; y0_q <= y0_d;
      x1_q <= x1_d; y1_q <= y1_d;
      x2_q <= x2_d; y2_q <= y2_d;
      cx_q <= cx_d; cy_q <= cy_d;
      a2_q <= a2_d;
      po_q <= po_d;
      xo_q <= xo_d;
      yo_q <= yo_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == FIN);
  assign bus.po   = po_q;
  assign bus.xo   = xo_q;
  assign bus.yo   = yo_q;

`ifdef TRI_RASTER_COUNT_EN
  logic [2*CW:0] pix_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt_q <= '0;
    end else if ((state_q == IDLE) && bus.nt) begin
      pix_cnt_q <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_q + (2*CW+1)'(po_q);
    end
  end

  assign pix_cnt = pix_cnt_q;
`endif
endmodule

// File: tb/tb_tri_raster_gen.sv
// Directed bench for tri_raster_gen: pixel sequences, latency, degenerate, full-range,
// reset abort and ignored nt, with hand-computed expectations.
module tb_tri_raster_gen;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset;
  tri_raster_gen_if #(.CW(CW)) bus_if();
`ifdef TRI_RASTER_COUNT_EN
  logic [2*CW:0] pix_cnt;
`endif

  tri_raster_gen #(.CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
`ifdef TRI_RASTER_COUNT_EN
    ,
    .pix_cnt (pix_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int got_q[$];
  int exp_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pixels are encoded as x*16+y.
  task automatic run_tri(input string tag, input int ax, ay, bx, by, qx, qy,
                         input int spur, input int rst_po,
                         output int first_cyc, output int done_cyc);
    int cyc;
    int bad;
    bit fin;
    cyc = 0; bad = 0; fin = 0;
    first_cyc = -1; done_cyc = -1;
    got_q.delete();
    check({tag, "_idle_busy"}, int'(bus_if.busy), 0);
    bus_if.nt = 1'b1; bus_if.xi = CW'(ax); bus_if.yi = CW'(ay);
    for (int k = 0; k < 150; k++) begin
      step();
      cyc++;
      bus_if.nt = 1'b0; bus_if.xi = '0; bus_if.yi = '0;
      if (cyc == 1) begin bus_if.xi = CW'(bx); bus_if.yi = CW'(by); end
      if (cyc == 2) begin bus_if.xi = CW'(qx); bus_if.yi = CW'(qy); end
      if (cyc == spur) begin bus_if.nt = 1'b1; bus_if.xi = '1; bus_if.yi = '1; end
      if (cyc == 1) check({tag, "_busy_load"}, int'(bus_if.busy), 1);
      if (bus_if.po) begin
        got_q.push_back(int'(bus_if.xo) * 16 + int'(bus_if.yo));
        if (first_cyc < 0) first_cyc = cyc;
      end else if (bus_if.xo != '0 || bus_if.yo != '0) begin
        bad++;
      end
      if (rst_po > 0 && bus_if.po && got_q.size() == rst_po) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        check({tag, "_rst_po"}, int'(bus_if.po), 0);
        check({tag, "_rst_busy"}, int'(bus_if.busy), 0);
        check({tag, "_rst_done"}, int'(bus_if.done), 0);
`ifdef TRI_RASTER_COUNT_EN
        check({tag, "_rst_cnt"}, int'(pix_cnt), 0);
`endif
        for (int j = 0; j < 4; j++) begin
          if (bus_if.po || bus_if.done || bus_if.busy) bad++;
          step();
        end
        fin = 1;
      end else if (bus_if.done) begin
        done_cyc = cyc;
        check({tag, "_busy_at_done"}, int'(bus_if.busy), 1);
        step();
        check({tag, "_busy_after"}, int'(bus_if.busy), 0);
        check({tag, "_done_width"}, int'(bus_if.done), 0);
`ifdef TRI_RASTER_COUNT_EN
        check({tag, "_pix_cnt"}, int'(pix_cnt), got_q.size());
`endif
        fin = 1;
      end
      if (fin) break;
    end
    check({tag, "_terminated"}, int'(fin), 1);
    check({tag, "_quiet_outputs"}, bad, 0);
  endtask

  task automatic compare_seq(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_pix%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  int first_c, done_c;

  initial begin
    reset = 1'b1;
    bus_if.nt = 1'b0; bus_if.xi = '0; bus_if.yi = '0;
    step(); step(); step();
    check("reset_busy", int'(bus_if.busy), 0);
    check("reset_po", int'(bus_if.po), 0);
    check("reset_done", int'(bus_if.done), 0);
    check("reset_xo", int'(bus_if.xo), 0);
    check("reset_yo", int'(bus_if.yo), 0);
    reset = 1'b0;
    step();

    // Right triangle with vertical and horizontal legs, negative area.
    exp_q = '{16, 17, 33, 18, 34, 50, 19, 35, 51, 67};
    run_tri("t031", 1, 0, 1, 3, 4, 3, -1, -1, first_c, done_c);
    compare_seq("t031");
    check("t031_first_po", first_c, 5);
    check("t031_done_cyc", done_c, 20);

    run_tri("t032", 1, 3, 1, 0, 4, 3, -1, -1, first_c, done_c);
    compare_seq("t032");
    check("t032_first_po", first_c, 5);
    check("t032_done_cyc", done_c, 20);

    exp_q.delete();
    run_tri("t033", 0, 0, 2, 2, 5, 5, -1, -1, first_c, done_c);
    compare_seq("t033");
    check("t033_first_po", first_c, -1);
    check("t033_done_cyc", done_c, 4);

    // Full-range triangle x+y<=7, 64 candidates.
    exp_q.delete();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        if (x + y <= 7) exp_q.push_back(x * 16 + y);
    run_tri("t034", 0, 0, 7, 0, 0, 7, -1, -1, first_c, done_c);
    compare_seq("t034");
    if (got_q.size() > 0) check("t034_last", got_q[got_q.size()-1], 7);
    else check("t034_last", -1, 7);
    check("t034_done_cyc", done_c, 68);

    exp_q = '{16, 17, 33};
    run_tri("t035", 1, 0, 1, 3, 4, 3, -1, 3, first_c, done_c);
    compare_seq("t035");
    check("t035_no_done", done_c, -1);

    exp_q = '{16, 17, 33, 18, 34, 50, 19, 35, 51, 67};
    run_tri("t035b", 1, 0, 1, 3, 4, 3, -1, -1, first_c, done_c);
    compare_seq("t035b");
    check("t035b_done_cyc", done_c, 20);

    run_tri("t036", 1, 0, 1, 3, 4, 3, 8, -1, first_c, done_c);
    compare_seq("t036");
    check("t036_done_cyc", done_c, 20);

    // Reset wins over nt in the same cycle.
    reset = 1'b1; bus_if.nt = 1'b1; bus_if.xi = 3'd2; bus_if.yi = 3'd2;
    step();
    reset = 1'b0; bus_if.nt = 1'b0; bus_if.xi = '0; bus_if.yi = '0;
    check("rst_nt_busy", int'(bus_if.busy), 0);
    step();
    check("rst_nt_busy_later", int'(bus_if.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
